// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// Holds the FSM state encoding, word width and default fill pattern.
package mem_pkg;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;
    localparam logic [WORD_W-1:0] PATTERN_BASE_DEF = 32'h1000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/mem_array.sv
// Word storage with combinational read and synchronous write.
// Each word powers up holding PATTERN_BASE plus its index.
module mem_array import mem_pkg::*; #(
    parameter int DEPTH = 256,
    parameter logic [WORD_W-1:0] PATTERN_BASE = PATTERN_BASE_DEF,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_idx,
    output logic [WORD_W-1:0] rd_data
);
    logic [WORD_W-1:0] words [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [WORD_W-1:0] word = PATTERN_BASE + WORD_W'(i);

        // Overwrite this word when the write port selects it
        always_ff @(posedge clk) begin
            if (we && wr_idx == AW'(i)) begin
                word <= wr_data;
            end
        end

        assign words[i] = word;
    end

    assign rd_data = words[rd_idx];
endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request at a time, waits LATENCY
// cycles, then answers for one cycle on a shared tristate data bus.
module mem_responder import mem_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int LATENCY = 2,
    parameter logic [WORD_W-1:0] PATTERN_BASE = PATTERN_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce,
    input  logic              mem_rw,
    input  logic [31:0]       mem_addr,
    inout  wire  [WORD_W-1:0] mem_data,
    output logic              mem_hold,
    output logic              mem_err
);
    localparam int IDX = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_START =
        (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX-1:0]    idx_q;
    logic              rw_q;
    logic              oor_q;
    logic [WORD_W-1:0] wdata_q;
    logic              drive_q;
    logic              err_q;

    logic [IDX-1:0]    idx_in;
    logic              oor_in;
    logic              idle_acc;
    logic              go_resp;
    logic [IDX-1:0]    wr_idx;
    logic [WORD_W-1:0] wr_data;
    logic              wr_rw;
    logic              wr_oor;
    logic              we;
    logic [WORD_W-1:0] rd_word;
    logic              unused_lsb;

    assign idx_in     = mem_addr[IDX+1:2];
    assign oor_in     = |mem_addr[31:IDX+2];
    assign unused_lsb = ^mem_addr[1:0];

    // With zero latency the acceptance edge is also the write edge,
    // so the write port must take the live request, not the latch.
    always_comb begin
        idle_acc = (state == IDLE) && mem_ce;
        go_resp  = (idle_acc && LATENCY == 0)
                || (state == WAIT && mem_ce && cnt == '0);
        wr_idx   = idle_acc ? idx_in   : idx_q;
        wr_data  = idle_acc ? mem_data : wdata_q;
        wr_rw    = idle_acc ? mem_rw   : rw_q;
        wr_oor   = idle_acc ? oor_in   : oor_q;
        we       = go_resp && !wr_rw && !wr_oor;
    end

    // Request sequencing: accept, count down, respond for one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            drive_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            drive_q <= 1'b0;
            err_q   <= 1'b0;
            if (go_resp) begin
                drive_q <= wr_rw;
                err_q   <= wr_oor;
            end
            unique case (state)
                IDLE: begin
                    if (mem_ce) begin
                        idx_q <= idx_in;
                        rw_q  <= mem_rw;
                        oor_q <= oor_in;
                        if (!mem_rw) begin
                            wdata_q <= mem_data;
                        end
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_START;
                        end
                    end
                end
                WAIT: begin
                    if (!mem_ce) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_hold = rst && mem_ce && (state == IDLE || state == WAIT);
    assign mem_err  = err_q;
    assign mem_data = drive_q ? (oor_q ? '0 : rd_word) : 'z;

    mem_array #(
        .DEPTH        (DEPTH),
        .PATTERN_BASE (PATTERN_BASE)
    ) u_array (
        .clk     (clk),
        .we      (we),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (idx_q),
        .rd_data (rd_word)
    );
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder at latencies 2, 0 and 4.
// The bench drives the bus whenever the DUT must not.
module tb_mem_responder;
    localparam int N = 3;

    typedef struct packed {
        logic [1:0]  inst;
        logic        rd;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]       ce;
    logic [N-1:0]       rw;
    logic [N-1:0][31:0] addr;
    logic [N-1:0][31:0] dout;
    logic [N-1:0]       hold;
    logic [N-1:0]       err;
    logic [N-1:0][31:0] bus_rd;

    resp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_dut
        localparam int L = (k == 0) ? 2 : ((k == 1) ? 0 : 4);
        wire [31:0] bus;
        logic tb_en;
        assign tb_en = !(rst && ce[k] && rw[k] && !hold[k]);
        assign bus = tb_en ? dout[k] : 'z;
        assign bus_rd[k] = bus;

        mem_responder #(
            .DEPTH        (256),
            .LATENCY      (L),
            .PATTERN_BASE (32'h1000_0000)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .mem_ce   (ce[k]),
            .mem_rw   (rw[k]),
            .mem_addr (addr[k]),
            .mem_data (bus),
            .mem_hold (hold[k]),
            .mem_err  (err[k])
        );
    end

    // Monitor: a response is a cycle with the request up and hold low
    always @(negedge clk) begin
        resp_t e;
        for (int k = 0; k < N; k++) begin
            if (rst && ce[k] && !hold[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp inst=%0d", k);
                end else begin
                    e = exp_q.pop_front();
                    if (e.inst != 2'(k) || e.err !== err[k]) begin
                        failures++;
                        $display("FAIL resp_err inst=%0d got err=%0b want inst=%0d err=%0b",
                                 k, err[k], e.inst, e.err);
                    end
                    checks++;
                    if (e.rd) begin
                        if (bus_rd[k] !== e.data) begin
                            failures++;
                            $display("FAIL rd_data inst=%0d got %h want %h",
                                     k, bus_rd[k], e.data);
                        end
                    end else if (bus_rd[k] !== dout[k]) begin
                        failures++;
                        $display("FAIL wr_bus inst=%0d got %h want %h",
                                 k, bus_rd[k], dout[k]);
                    end
                end
            end else begin
                checks++;
                if (err[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_err inst=%0d got %0b want 0", k, err[k]);
                end
                checks++;
                if (bus_rd[k] !== dout[k]) begin
                    failures++;
                    $display("FAIL bus_driven inst=%0d got %h want %h",
                             k, bus_rd[k], dout[k]);
                end
            end
        end
    end

    task automatic count_hold(input int k, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!hold[k]) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
    endtask

    task automatic check_hold(input string name, input int n, input bit ok,
                              input int want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout got no response want %0d hold cycles",
                     name, want);
        end else if (n != want) begin
            failures++;
            $display("FAIL %s_hold got %0d want %0d", name, n, want);
        end
    endtask

    // Starts just after a rising edge; the request is scrambled after
    // acceptance so any use of live inputs shows up as bad data.
    task automatic req(input int k, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ed,
                       input logic ee, input string name);
        int n;
        int m;
        bit ok;
        exp_q.push_back('{inst: 2'(k), rd: r, data: ed, err: ee});
        ce[k] = 1'b1;
        rw[k] = r;
        addr[k] = a;
        dout[k] = d;
        @(negedge clk);
        n = hold[k] ? 1 : 0;
        @(posedge clk);
        #1;
        addr[k] = ~a;
        dout[k] = ~d;
        count_hold(k, m, ok);
        check_hold(name, n + m, ok, lat_of(k) + 1);
        @(posedge clk);
        #1;
        ce[k] = 1'b0;
        dout[k] = '0;
    endtask

    initial begin
        int n;
        bit ok;
        rst = 1'b0;
        ce = '0;
        rw = '0;
        addr = '0;
        dout = '0;
        ce[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hold !== 3'b000) begin
            failures++;
            $display("FAIL reset_hold got %b want 000", hold);
        end
        checks++;
        if (err !== 3'b000) begin
            failures++;
            $display("FAIL reset_err got %b want 000", err);
        end
        ce[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        req(0, 1'b1, 32'h20, 32'h0, 32'h1000_0008, 1'b0, "rd20");
        req(0, 1'b1, 32'h23, 32'h0, 32'h1000_0008, 1'b0, "rd23");
        req(0, 1'b1, 32'h3FC, 32'h0, 32'h1000_00FF, 1'b0, "rd_last");
        req(0, 1'b1, 32'h400, 32'h0, 32'h0, 1'b1, "rd_oor");
        req(0, 1'b1, 32'h8000_0020, 32'h0, 32'h0, 1'b1, "rd_oor_msb");
        req(0, 1'b0, 32'h400, 32'h5555_AAAA, 32'h0, 1'b1, "wr_oor");
        req(0, 1'b1, 32'h0, 32'h0, 32'h1000_0000, 1'b0, "rd0");
        req(0, 1'b0, 32'h40, 32'hA5A5_0001, 32'h0, 1'b0, "wr40");
        req(0, 1'b1, 32'h40, 32'h0, 32'hA5A5_0001, 1'b0, "rd40");

        req(1, 1'b0, 32'h24, 32'hCAFE_F00D, 32'h0, 1'b0, "l0_wr24");
        req(1, 1'b1, 32'h24, 32'h0, 32'hCAFE_F00D, 1'b0, "l0_rd24");

        ce[2] = 1'b1;
        rw[2] = 1'b0;
        addr[2] = 32'h28;
        dout[2] = 32'h1234_5678;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (hold[2] !== 1'b1) begin
            failures++;
            $display("FAIL abort_wait_hold got %0b want 1", hold[2]);
        end
        ce[2] = 1'b0;
        #1;
        checks++;
        if (hold[2] !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold got %0b want 0", hold[2]);
        end
        @(posedge clk);
        #1;
        dout[2] = '0;
        req(2, 1'b1, 32'h28, 32'h0, 32'h1000_000A, 1'b0, "abort_rd28");

        ce[2] = 1'b1;
        rw[2] = 1'b0;
        addr[2] = 32'h2C;
        dout[2] = 32'hDEAD_BEEF;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (hold[2] !== 1'b0 || err[2] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got hold=%0b err=%0b want 0 0",
                     hold[2], err[2]);
        end
        checks++;
        if (bus_rd[2] !== dout[2]) begin
            failures++;
            $display("FAIL rst_mid_bus got %h want %h", bus_rd[2], dout[2]);
        end
        ce[2] = 1'b0;
        dout[2] = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        req(2, 1'b1, 32'h2C, 32'h0, 32'h1000_000B, 1'b0, "rst_rd2c");

        exp_q.push_back('{inst: 2'd0, rd: 1'b1, data: 32'h1000_0008, err: 1'b0});
        ce[0] = 1'b1;
        rw[0] = 1'b1;
        addr[0] = 32'h20;
        count_hold(0, n, ok);
        check_hold("b2b_first", n, ok, 3);
        addr[0] = 32'h30;
        exp_q.push_back('{inst: 2'd0, rd: 1'b1, data: 32'h1000_000C, err: 1'b0});
        @(negedge clk);
        checks++;
        if (hold[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept got hold=%0b want 1", hold[0]);
        end
        count_hold(0, n, ok);
        check_hold("b2b_second", n, ok, 2);
        @(posedge clk);
        #1;
        ce[0] = 1'b0;

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_resp got %0d left want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning number of 32-bit words (power of two, 4..1024).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and response (0..15).
REQ-003 The block SHALL have parameter PATTERN_BASE, default 32'h1000_0000, meaning initial content of word i = PATTERN_BASE + i.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning the asynchronous active-low reset.
REQ-007 The block SHALL have port mem_ce, input, 1, meaning a request is present.
REQ-008 The block SHALL have port mem_rw, input, 1, meaning 1 = read and 0 = write.
REQ-009 The block SHALL have port mem_addr, input, 32, meaning byte address; word index = mem_addr[IDX+1:2], IDX = log2(DEPTH).
REQ-010 The block SHALL have port mem_data, inout, 32, meaning the shared data bus, driven by the block only in RESP of a read.
REQ-011 The block SHALL have port mem_hold, output, 1, meaning requester must keep the request stable.
REQ-012 The block SHALL have port mem_err, output, 1, meaning the current response is an out-of-range access.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, RESP and no others.
REQ-014 In IDLE with mem_ce=1, mem_hold SHALL be 1 combinationally, and the rising edge SHALL latch addr, rw and (for writes) mem_data as acceptance edge E0.
REQ-015 After E0 the FSM SHALL go to WAIT when LATENCY>0 with counter = LATENCY-1, or to RESP when LATENCY=0.
REQ-016 In WAIT, mem_hold SHALL be 1; the counter SHALL decrement each edge, and the FSM SHALL enter RESP on the edge where the counter is 0.
REQ-017 RESP SHALL last exactly one cycle, then the FSM SHALL return to IDLE; total latency is E0 to RESP = LATENCY+1 edges.
REQ-018 In RESP, mem_hold SHALL be 0; for reads, mem_data SHALL be driven with array[index]; the requester samples mem_data at the edge ending RESP.
REQ-019 For writes, the latched data SHALL be written to the array on the edge entering RESP, and mem_data SHALL stay Z.
REQ-020 mem_data SHALL be Z in every state except RESP-read.
REQ-021 Address bits [1:0] SHALL be ignored.
REQ-022 Any nonzero bit of mem_addr[31:IDX+2] SHALL make the access out of range: mem_err=1 during RESP only, read data = 32'h0000_0000, write discarded.
REQ-023 If mem_ce falls in WAIT, the request SHALL be aborted: return to IDLE next edge, no array write, mem_hold=0 from that cycle.
REQ-024 Changes to mem_addr, mem_rw or mem_data after E0 SHALL be ignored.
REQ-025 A request is accepted only in IDLE; mem_ce held high through RESP SHALL be treated as a new request in the following IDLE cycle.
REQ-026 The array SHALL be read combinationally and written synchronously.
REQ-027 The array SHALL be initialised at time zero to PATTERN_BASE + i.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, counter=0, mem_hold=0, mem_err=0 and mem_data=Z.
REQ-029 Array contents SHALL be unaffected by reset.
REQ-030 Reset mid-WAIT SHALL cancel the pending write.
REQ-031 Operation SHALL resume on the first rising edge after rst returns high.

Structure
REQ-032 A shared package mem_pkg SHALL hold the state enumeration (IDLE, WAIT, RESP), WORD_W=32 and the default PATTERN_BASE.
REQ-033 Storage SHALL be a single sub-module mem_array (DEPTH x 32, combinational read port, synchronous write port with enable).
REQ-034 The FSM, counter and tristate control SHALL reside in mem_responder.

Verification
REQ-035 Read, LATENCY=2: read 0x20 -> mem_hold=1 for 3 cycles from request, then RESP with mem_data=32'h1000_0008, mem_err=0.
REQ-036 Write then read, LATENCY=0: write 0x24 with 32'hCAFE_F00D, then read 0x24 -> RESP one edge after E0, mem_data=32'hCAFE_F00D.
REQ-037 Out of range, DEPTH=256: read 0x0000_0400 -> mem_err=1 in RESP, mem_data=0; write 0x400 followed by read 0x0 -> returns 32'h1000_0000 unchanged.
REQ-038 Abort: write 0x28 with 32'h1234_5678, LATENCY=4, mem_ce dropped in WAIT -> IDLE next edge, read 0x28 returns 32'h1000_000A.
REQ-039 Reset mid-operation: rst low during WAIT of a write to 0x2C -> mem_hold=0 and mem_data=Z immediately; word 0x2C still 32'h1000_000B.
REQ-040 Back-to-back: mem_ce held high across two reads (0x20, then 0x30 changed in RESP) -> second acceptance in the cycle after RESP, data 32'h1000_000C; bus never driven outside RESP.
